// File: rtl/bus_downsizer_if.sv
// Stream interface for the bus downsizer: wide word in, narrow beats out.
// "slave" is the downsizer's view; "master" is the view of whatever drives it.
interface bus_downsizer_if #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8
);
  logic                    s_val;
  logic [S_DATA_WIDTH-1:0] s_data;
  logic                    s_last;
  logic                    s_rdy;
  logic                    m_val;
  logic [M_DATA_WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    m_rdy;

  modport slave (
    input  s_val, s_data, s_last, m_rdy,
    output s_rdy, m_val, m_data, m_last
  );

  modport master (
    output s_val, s_data, s_last, m_rdy,
    input  s_rdy, m_val, m_data, m_last
  );
endinterface

// File: rtl/bus_downsizer.sv
// Splits each wide word into RATIO narrow beats, MSB or LSB lane first,
// with a single holding register and no bubble between consecutive words.
module bus_downsizer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8,
  parameter bit MSB_FIRST    = 1'b1
) (
  input logic            clock,
  input logic            reset,
  bus_downsizer_if.slave bus
);
  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  generate
    if ((RATIO < 2) || (RATIO * M_DATA_WIDTH != S_DATA_WIDTH)) begin : g_bad_ratio
      $error("bus_downsizer: S_DATA_WIDTH/M_DATA_WIDTH must be an integer >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx, w_cnt_inc;
  logic [S_DATA_WIDTH-1:0] r_hold, w_hold_nx;
  logic                    r_hold_last, w_hold_last_nx;
  logic                    r_m_val, w_m_val_nx;
  logic [M_DATA_WIDTH-1:0] r_m_data, w_m_data_nx;
  logic                    r_m_last, w_m_last_nx;
  logic                    w_s_rdy, w_s_fire, w_m_fire;

  function automatic logic [M_DATA_WIDTH-1:0] laneOf(input logic [S_DATA_WIDTH-1:0] word,
                                                     input logic [CW-1:0] idx);
    logic [S_DATA_WIDTH-1:0] shifted;
    if (MSB_FIRST) begin
      shifted = word << (int'(idx) * M_DATA_WIDTH);
      return shifted[S_DATA_WIDTH-1 -: M_DATA_WIDTH];
    end else begin
      shifted = word >> (int'(idx) * M_DATA_WIDTH);
      return shifted[M_DATA_WIDTH-1:0];
    end
  endfunction

  // Accept a new word while idle, or in the same edge the last beat leaves.
  assign w_s_rdy   = reset && ((r_state == IDLE) || ((r_cnt == LAST_IDX) && bus.m_rdy));
  assign w_s_fire  = bus.s_val && w_s_rdy;
  assign w_m_fire  = r_m_val && bus.m_rdy;
  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_s_fire) w_state_nx = SEND;
      SEND:    if (w_m_fire && (r_cnt == LAST_IDX) && !w_s_fire) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nx       = r_cnt;
    w_hold_nx      = r_hold;
    w_hold_last_nx = r_hold_last;
    w_m_val_nx     = r_m_val;
    w_m_data_nx    = r_m_data;
    w_m_last_nx    = r_m_last;
    if (w_s_fire) begin
      w_cnt_nx       = '0;
      w_hold_nx      = bus.s_data;
      w_hold_last_nx = bus.s_last;
      w_m_val_nx     = 1'b1;
      w_m_data_nx    = laneOf(bus.s_data, '0);
      w_m_last_nx    = 1'b0;
    end else if (w_m_fire) begin
      if (r_cnt != LAST_IDX) begin
        w_cnt_nx    = w_cnt_inc;
        w_m_data_nx = laneOf(r_hold, w_cnt_inc);
        w_m_last_nx = r_hold_last && (w_cnt_inc == LAST_IDX);
      end else begin
        w_m_val_nx  = 1'b0;
        w_m_last_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
      r_m_val     <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nx;
      r_hold      <= w_hold_nx;
      r_hold_last <= w_hold_last_nx;
      r_m_val     <= w_m_val_nx;
      r_m_data    <= w_m_data_nx;
      r_m_last    <= w_m_last_nx;
    end
  end

  assign bus.s_rdy  = w_s_rdy;
  assign bus.m_val  = r_m_val;
  assign bus.m_data = r_m_data;
  assign bus.m_last = r_m_last;
endmodule

// File: tb/tb_bus_downsizer.sv
// Directed bench for bus_downsizer: one MSB-first and one LSB-first instance
// sharing clock and reset, outputs checked 1 ns after each falling edge.
module tb_bus_downsizer;
  logic clock = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   failCount  = 0;

  bus_downsizer_if #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) busMsb ();
  bus_downsizer_if #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) busLsb ();

  bus_downsizer #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
    .clock(clock), .reset(reset), .bus(busMsb)
  );
  bus_downsizer #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .clock(clock), .reset(reset), .bus(busLsb)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic val, input logic [31:0] data, input logic last, input logic rdy);
    busMsb.s_val  = val;
    busMsb.s_data = data;
    busMsb.s_last = last;
    busMsb.m_rdy  = rdy;
  endtask

  task automatic checkBeat(input string tag, input logic val, input logic [7:0] data,
                           input logic last, input logic srdy);
    checkOutput({tag, ".m_val"},  32'(busMsb.m_val),  32'(val));
    checkOutput({tag, ".m_data"}, 32'(busMsb.m_data), 32'(data));
    checkOutput({tag, ".m_last"}, 32'(busMsb.m_last), 32'(last));
    checkOutput({tag, ".s_rdy"},  32'(busMsb.s_rdy),  32'(srdy));
  endtask

  logic [7:0] expSingle [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] expB2b    [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] expCafe   [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
  logic [7:0] expLsb    [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

  initial begin
    reset = 1'b0;
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    busLsb.s_val  = 1'b0;
    busLsb.s_data = '0;
    busLsb.s_last = 1'b0;
    busLsb.m_rdy  = 1'b1;

    // Reset held with s_val high: everything quiet, s_rdy forced low
    #1;
    checkBeat("rst_noclk", 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    checkBeat("rst_clocked", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    checkBeat("rst_release", 1'b0, 8'h00, 1'b0, 1'b1);

    // Single word, MSB first
    @(negedge clock);
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1, 1'b1);
    #1;
    checkOutput("single.accept_rdy", 32'(busMsb.s_rdy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkBeat($sformatf("single.beat%0d", k), 1'b1, expSingle[k], k == 3, k == 3);
    end
    @(negedge clock);
    #1;
    checkBeat("single.idle", 1'b0, 8'hD4, 1'b0, 1'b1);

    // Back-to-back words with no bubble
    @(negedge clock);
    applyStimulus(1'b1, 32'h11223344, 1'b0, 1'b1);
    #1;
    checkOutput("b2b.accept_rdy", 32'(busMsb.s_rdy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) applyStimulus(1'b1, 32'h55667788, 1'b1, 1'b1);
      if (i == 7) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkBeat($sformatf("b2b.beat%0d", i), 1'b1, expB2b[i], i == 7, (i == 3) || (i == 7));
    end
    @(negedge clock);
    #1;
    checkBeat("b2b.idle", 1'b0, 8'h88, 1'b0, 1'b1);

    // Backpressure on B2; garbage on s_data while s_rdy is low must be ignored
    @(negedge clock);
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkBeat("bp.beat0", 1'b1, 8'hA1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
      #1;
      checkBeat($sformatf("bp.hold%0d", c), 1'b1, 8'hB2, 1'b0, 1'b0);
    end
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkBeat("bp.hold_release", 1'b1, 8'hB2, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    checkBeat("bp.beat2", 1'b1, 8'hC3, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    checkBeat("bp.beat3", 1'b1, 8'hD4, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    checkBeat("bp.idle", 1'b0, 8'hD4, 1'b0, 1'b1);

    // Reset pulse after B2 drops the rest of the word
    @(negedge clock);
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkBeat("midrst.beat0", 1'b1, 8'hA1, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    checkBeat("midrst.beat1", 1'b1, 8'hB2, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkBeat("midrst.async", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    #1;
    checkOutput("midrst.accept_rdy", 32'(busMsb.s_rdy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkBeat($sformatf("midrst.cafe%0d", k), 1'b1, expCafe[k], k == 3, k == 3);
    end
    @(negedge clock);
    #1;
    checkBeat("midrst.idle", 1'b0, 8'h0D, 1'b0, 1'b1);

    // LSB-first instance
    @(negedge clock);
    busLsb.s_val  = 1'b1;
    busLsb.s_data = 32'hA1B2C3D4;
    busLsb.s_last = 1'b1;
    #1;
    checkOutput("lsb.accept_rdy", 32'(busLsb.s_rdy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      busLsb.s_val = 1'b0;
      #1;
      checkOutput($sformatf("lsb.beat%0d.m_val", k),  32'(busLsb.m_val),  32'd1);
      checkOutput($sformatf("lsb.beat%0d.m_data", k), 32'(busLsb.m_data), 32'(expLsb[k]));
      checkOutput($sformatf("lsb.beat%0d.m_last", k), 32'(busLsb.m_last), 32'(k == 3));
    end
    @(negedge clock);
    #1;
    checkOutput("lsb.idle.m_val", 32'(busLsb.m_val), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
